// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: ALU op codes, link register and the packed
// Controller bundle carried from decode into the execute stage.
package id_ex_stage_pkg;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_XOR = 4'd5,
        ALU_NOR = 4'd6,
        ALU_SLT = 4'd7,
        ALU_SLL = 4'd8,
        ALU_SRL = 4'd9,
        ALU_BEQ = 4'd10,
        ALU_BNE = 4'd11
    } alu_op_e;

    localparam logic [4:0] JAL_REG  = 5'd31;
    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       jal;
        logic       jr;
        logic       lw_or_lh;
        logic       sw_or_sh;
        logic [3:0] alu_op;
    } ctrl_t;

    // Write-back target: jal links into $31, R-type writes rd, others rt.
    function automatic logic [4:0] dest_reg(
        input logic       jal,
        input logic       reg_dst,
        input logic [4:0] rt,
        input logic [4:0] rd
    );
        logic [4:0] r;
        r = reg_dst ? rd : rt;
        if (jal) begin
            r = JAL_REG;
        end
        return r;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use detector: a load sitting in EX whose destination is
// a source register actually read by the instruction currently in ID.
module id_ex_stage_hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic       id_valid,
    input  logic       id_jump,
    input  logic       id_jr,
    input  logic       id_alu_src,
    input  logic       id_mem_write,
    input  logic [3:0] id_alu_op,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_valid,
    input  logic       ex_mem_to_reg,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_wreg,
    output logic       load_use
);

    logic uses_rs;
    logic uses_rt;
    logic ex_is_load;
    logic rs_match;
    logic rt_match;

    always_comb begin
        // Plain jumps and shifts never read rs; jr does.
        uses_rs    = !(id_jump && !id_jr) && (id_alu_op != ALU_SLL) && (id_alu_op != ALU_SRL);
        // Immediate forms ignore rt except stores, which read it as data.
        uses_rt    = !id_alu_src || id_mem_write;
        ex_is_load = ex_valid && ex_mem_to_reg && ex_reg_write && (ex_wreg != ZERO_REG);
        rs_match   = uses_rs && (ex_wreg == id_rs);
        rt_match   = uses_rt && (ex_wreg == id_rt);
        load_use   = id_valid && ex_is_load && (rs_match || rt_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode results, resolves the EX write
// register, stalls on load-use, bubbles on flush and counts inserted bubbles.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              id_valid,
    input  logic              id_RegDst,
    input  logic              id_RegWrite,
    input  logic              id_ALUSrc,
    input  logic              id_MemWrite,
    input  logic              id_MemtoReg,
    input  logic              id_Branch,
    input  logic              id_Jump,
    input  logic              id_Jal,
    input  logic              id_Jr,
    input  logic              id_lw_or_lh,
    input  logic              id_sw_or_sh,
    input  logic [3:0]        id_ALUOp,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_shamt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    output logic              ex_valid,
    output logic              ex_RegDst,
    output logic              ex_RegWrite,
    output logic              ex_ALUSrc,
    output logic              ex_MemWrite,
    output logic              ex_MemtoReg,
    output logic              ex_Branch,
    output logic              ex_Jump,
    output logic              ex_Jal,
    output logic              ex_Jr,
    output logic              ex_lw_or_lh,
    output logic              ex_sw_or_sh,
    output logic [3:0]        ex_ALUOp,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [4:0]        ex_shamt,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [4:0]        ex_wreg,
    output logic              pc_write,
    output logic              ifid_write,
    output logic [CNT_W-1:0]  bubble_cnt
);
    import id_ex_stage_pkg::*;

    ctrl_t             id_ctrl;
    ctrl_t             ctrl_reg;
    ctrl_t             ctrl_next;
    logic              valid_reg;
    logic              valid_next;
    logic [4:0]        wreg_reg;
    logic [4:0]        wreg_next;
    logic [4:0]        rs_reg;
    logic [4:0]        rt_reg;
    logic [4:0]        rd_reg;
    logic [4:0]        shamt_reg;
    logic [DATA_W-1:0] rs_data_reg;
    logic [DATA_W-1:0] rt_data_reg;
    logic [DATA_W-1:0] imm_reg;
    logic [DATA_W-1:0] pc4_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic              load_use;
    logic              stall;
    logic              bubble;

    assign id_ctrl = '{
        reg_dst:    id_RegDst,
        reg_write:  id_RegWrite,
        alu_src:    id_ALUSrc,
        mem_write:  id_MemWrite,
        mem_to_reg: id_MemtoReg,
        branch:     id_Branch,
        jump:       id_Jump,
        jal:        id_Jal,
        jr:         id_Jr,
        lw_or_lh:   id_lw_or_lh,
        sw_or_sh:   id_sw_or_sh,
        alu_op:     id_ALUOp
    };

    id_ex_stage_hazard_detect u_hazard_detect (
        .id_valid      (id_valid),
        .id_jump       (id_Jump),
        .id_jr         (id_Jr),
        .id_alu_src    (id_ALUSrc),
        .id_mem_write  (id_MemWrite),
        .id_alu_op     (id_ALUOp),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .ex_valid      (valid_reg),
        .ex_mem_to_reg (ctrl_reg.mem_to_reg),
        .ex_reg_write  (ctrl_reg.reg_write),
        .ex_wreg       (wreg_reg),
        .load_use      (load_use)
    );

    always_comb begin
        // A flush overrides the stall so the branch redirect is not held off.
        stall      = load_use && !flush;
        bubble     = flush || load_use || !id_valid;
        pc_write   = rst || !(hold || stall);
        ifid_write = pc_write;
        ctrl_next  = bubble ? '0 : id_ctrl;
        valid_next = !bubble;
        wreg_next  = bubble ? ZERO_REG : dest_reg(id_Jal, id_RegDst, id_rt, id_rd);
        cnt_next   = cnt_reg;
        if (stall && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_reg    <= '0;
            valid_reg   <= 1'b0;
            wreg_reg    <= '0;
            rs_reg      <= '0;
            rt_reg      <= '0;
            rd_reg      <= '0;
            shamt_reg   <= '0;
            rs_data_reg <= '0;
            rt_data_reg <= '0;
            imm_reg     <= '0;
            pc4_reg     <= '0;
            cnt_reg     <= '0;
        end else if (!hold) begin
            ctrl_reg    <= ctrl_next;
            valid_reg   <= valid_next;
            wreg_reg    <= wreg_next;
            // Operand fields are captured even into a bubble; nothing reads them then.
            rs_reg      <= id_rs;
            rt_reg      <= id_rt;
            rd_reg      <= id_rd;
            shamt_reg   <= id_shamt;
            rs_data_reg <= id_rs_data;
            rt_data_reg <= id_rt_data;
            imm_reg     <= id_imm;
            pc4_reg     <= id_pc4;
            cnt_reg     <= cnt_next;
        end
    end

    assign ex_valid    = valid_reg;
    assign ex_RegDst   = ctrl_reg.reg_dst;
    assign ex_RegWrite = ctrl_reg.reg_write;
    assign ex_ALUSrc   = ctrl_reg.alu_src;
    assign ex_MemWrite = ctrl_reg.mem_write;
    assign ex_MemtoReg = ctrl_reg.mem_to_reg;
    assign ex_Branch   = ctrl_reg.branch;
    assign ex_Jump     = ctrl_reg.jump;
    assign ex_Jal      = ctrl_reg.jal;
    assign ex_Jr       = ctrl_reg.jr;
    assign ex_lw_or_lh = ctrl_reg.lw_or_lh;
    assign ex_sw_or_sh = ctrl_reg.sw_or_sh;
    assign ex_ALUOp    = ctrl_reg.alu_op;
    assign ex_rs       = rs_reg;
    assign ex_rt       = rt_reg;
    assign ex_rd       = rd_reg;
    assign ex_shamt    = shamt_reg;
    assign ex_rs_data  = rs_data_reg;
    assign ex_rt_data  = rt_data_reg;
    assign ex_imm      = imm_reg;
    assign ex_pc4      = pc4_reg;
    assign ex_wreg     = wreg_reg;
    assign bubble_cnt  = cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// instruction streams checked against a cycle-level behavioural model.
module tb_id_ex_stage;

    localparam int DATA_W  = 32;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int DD_W    = 20 + 4 * DATA_W;
    localparam int ST_W    = 1 + 15 + 5 + CNT_W;

    // Control order: RegDst RegWrite ALUSrc MemWrite MemtoReg Branch Jump Jal Jr lw sw ALUOp[3:0]
    localparam logic [14:0] CTL_ADD  = 15'b1_1_0_0_0_0_0_0_0_0_0_0001;
    localparam logic [14:0] CTL_LW   = 15'b0_1_1_0_1_0_0_0_0_1_0_0001;
    localparam logic [14:0] CTL_ADDI = 15'b0_1_1_0_0_0_0_0_0_0_0_0001;
    localparam logic [14:0] CTL_SLL  = 15'b1_1_0_0_0_0_0_0_0_0_0_1000;
    localparam logic [14:0] CTL_SW   = 15'b0_0_1_1_0_0_0_0_0_0_1_0001;
    localparam logic [14:0] CTL_BEQ  = 15'b0_0_0_0_0_1_0_0_0_0_0_1010;
    localparam logic [14:0] CTL_JAL  = 15'b0_1_0_0_0_0_1_1_0_0_0_0000;
    localparam logic [14:0] CTL_JR   = 15'b0_0_0_0_0_0_1_0_1_0_0_0000;
    localparam logic [14:0] CTL_J    = 15'b0_0_0_0_0_0_1_0_0_0_0_0000;
    localparam logic [14:0] KINDS [0:8] = '{CTL_ADD, CTL_LW, CTL_ADDI, CTL_SLL, CTL_SW,
                                           CTL_BEQ, CTL_JAL, CTL_JR, CTL_J};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b0, hold = 1'b0, flush = 1'b0, id_valid = 1'b0;
    logic              id_RegDst = 0, id_RegWrite = 0, id_ALUSrc = 0, id_MemWrite = 0;
    logic              id_MemtoReg = 0, id_Branch = 0, id_Jump = 0, id_Jal = 0, id_Jr = 0;
    logic              id_lw_or_lh = 0, id_sw_or_sh = 0;
    logic [3:0]        id_ALUOp = '0;
    logic [4:0]        id_rs = '0, id_rt = '0, id_rd = '0, id_shamt = '0;
    logic [DATA_W-1:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0, id_pc4 = '0;

    logic              ex_valid, ex_RegDst, ex_RegWrite, ex_ALUSrc, ex_MemWrite, ex_MemtoReg;
    logic              ex_Branch, ex_Jump, ex_Jal, ex_Jr, ex_lw_or_lh, ex_sw_or_sh;
    logic [3:0]        ex_ALUOp;
    logic [4:0]        ex_rs, ex_rt, ex_rd, ex_shamt, ex_wreg;
    logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
    logic              pc_write, ifid_write;
    logic [CNT_W-1:0]  bubble_cnt;

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_RegDst(id_RegDst), .id_RegWrite(id_RegWrite), .id_ALUSrc(id_ALUSrc),
        .id_MemWrite(id_MemWrite), .id_MemtoReg(id_MemtoReg), .id_Branch(id_Branch),
        .id_Jump(id_Jump), .id_Jal(id_Jal), .id_Jr(id_Jr), .id_lw_or_lh(id_lw_or_lh),
        .id_sw_or_sh(id_sw_or_sh), .id_ALUOp(id_ALUOp), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_shamt(id_shamt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_pc4(id_pc4),
        .ex_valid(ex_valid), .ex_RegDst(ex_RegDst), .ex_RegWrite(ex_RegWrite),
        .ex_ALUSrc(ex_ALUSrc), .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg),
        .ex_Branch(ex_Branch), .ex_Jump(ex_Jump), .ex_Jal(ex_Jal), .ex_Jr(ex_Jr),
        .ex_lw_or_lh(ex_lw_or_lh), .ex_sw_or_sh(ex_sw_or_sh), .ex_ALUOp(ex_ALUOp),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .ex_wreg(ex_wreg), .pc_write(pc_write), .ifid_write(ifid_write), .bubble_cnt(bubble_cnt)
    );

    wire [14:0] in_ctrl  = {id_RegDst, id_RegWrite, id_ALUSrc, id_MemWrite, id_MemtoReg, id_Branch,
                            id_Jump, id_Jal, id_Jr, id_lw_or_lh, id_sw_or_sh, id_ALUOp};
    wire [14:0] obs_ctrl = {ex_RegDst, ex_RegWrite, ex_ALUSrc, ex_MemWrite, ex_MemtoReg, ex_Branch,
                            ex_Jump, ex_Jal, ex_Jr, ex_lw_or_lh, ex_sw_or_sh, ex_ALUOp};
    wire [DD_W-1:0] in_data  = {id_rs, id_rt, id_rd, id_shamt, id_rs_data, id_rt_data, id_imm, id_pc4};
    wire [DD_W-1:0] obs_data = {ex_rs, ex_rt, ex_rd, ex_shamt, ex_rs_data, ex_rt_data, ex_imm, ex_pc4};
    wire [ST_W-1:0] obs_state = {ex_valid, obs_ctrl, ex_wreg, bubble_cnt};

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model of what EX should hold.
    logic           m_valid = 1'b0;
    logic [14:0]    m_ctrl  = '0;
    logic [4:0]     m_wreg  = '0;
    logic [DD_W-1:0] m_data = '0;
    int             m_cnt   = 0;

    function automatic logic [ST_W-1:0] exp_state();
        return {m_valid, m_ctrl, m_wreg, CNT_W'(m_cnt)};
    endfunction

    function automatic logic model_hazard();
        logic reads_rs, reads_rt, ex_load;
        reads_rs = !(id_Jump && !id_Jr) && id_ALUOp != 4'd8 && id_ALUOp != 4'd9;
        reads_rt = !id_ALUSrc || id_MemWrite;
        ex_load  = m_valid && m_ctrl[10] && m_ctrl[13] && m_wreg != 5'd0;
        return id_valid && ex_load && ((reads_rs && m_wreg == id_rs) || (reads_rt && m_wreg == id_rt));
    endfunction

    function automatic logic [1:0] exp_pc();
        if (rst) return 2'b11;
        return {2{!(hold || (model_hazard() && !flush))}};
    endfunction

    task automatic tick();
        logic hz;
        hz = model_hazard();
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_ctrl = '0; m_wreg = '0; m_data = '0; m_cnt = 0;
        end else if (!hold) begin
            m_data = in_data;
            if (flush || hz || !id_valid) begin
                m_valid = 1'b0; m_ctrl = '0; m_wreg = '0;
            end else begin
                m_valid = 1'b1;
                m_ctrl  = in_ctrl;
                m_wreg  = id_Jal ? 5'd31 : (id_RegDst ? id_rd : id_rt);
            end
            if (hz && !flush && m_cnt < CNT_MAX) m_cnt++;
        end
        #1;
    endtask

    task automatic drive(input logic [14:0] ctl, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd);
        {id_RegDst, id_RegWrite, id_ALUSrc, id_MemWrite, id_MemtoReg, id_Branch,
         id_Jump, id_Jal, id_Jr, id_lw_or_lh, id_sw_or_sh, id_ALUOp} = ctl;
        id_valid = 1'b1;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_shamt = 5'($urandom);
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom; id_pc4 = $urandom;
    endtask

    task automatic test_reset();
        drive(15'h7FFF, 5'd3, 5'd4, 5'd5);
        id_rs_data = 32'hDEAD_BEEF;
        hold = 1'b1; flush = 1'b1; rst = 1'b1;
        #1;
        n_cmp++;
        if ({pc_write, ifid_write} !== 2'b11) begin
            n_err++; $display("FAIL reset_pc_write: got %b want 11", {pc_write, ifid_write});
        end
        tick(); tick();
        n_cmp++;
        if (obs_state !== '0 || obs_data !== '0) begin
            n_err++; $display("FAIL reset_state: got %h/%h want 0", obs_state, obs_data);
        end
        rst = 1'b0; hold = 1'b0; flush = 1'b0; id_valid = 1'b0;
        #1;
        $display("test_reset: state=%h pc_write=%b", obs_state, pc_write);
    endtask

    task automatic test_capture();
        drive(CTL_ADD, 5'd1, 5'd2, 5'd5);
        id_rs_data = 32'h10; id_rt_data = 32'h20;
        #1; tick();
        n_cmp++;
        if ({ex_valid, ex_ALUOp, ex_wreg, ex_rs_data, ex_rt_data} !== {1'b1, 4'd1, 5'd5, 32'h10, 32'h20}) begin
            n_err++; $display("FAIL capture_add: got v=%b op=%0d wreg=%0d rs=%h rt=%h want 1/1/5/10/20",
                              ex_valid, ex_ALUOp, ex_wreg, ex_rs_data, ex_rt_data);
        end
        n_cmp++;
        if (obs_state !== exp_state() || obs_data !== m_data) begin
            n_err++; $display("FAIL capture_model: got %h want %h", obs_state, exp_state());
        end
        $display("test_capture: ex_ALUOp=%0d ex_wreg=%0d", ex_ALUOp, ex_wreg);
    endtask

    task automatic test_load_use();
        drive(CTL_LW, 5'd2, 5'd8, 5'd0);
        #1; tick();
        drive(CTL_ADD, 5'd8, 5'd3, 5'd9);
        #1;
        n_cmp++;
        if ({pc_write, ifid_write} !== 2'b00) begin
            n_err++; $display("FAIL load_use_stall: got %b want 00", {pc_write, ifid_write});
        end
        tick();
        n_cmp++;
        if ({ex_valid, ex_RegWrite, obs_ctrl} !== '0 || bubble_cnt !== CNT_W'(1)) begin
            n_err++; $display("FAIL load_use_bubble: got v=%b ctrl=%h cnt=%0d want 0/0/1",
                              ex_valid, obs_ctrl, bubble_cnt);
        end
        n_cmp++;
        if ({pc_write, ifid_write} !== 2'b11) begin
            n_err++; $display("FAIL load_use_release: got %b want 11", {pc_write, ifid_write});
        end
        tick();
        n_cmp++;
        if ({ex_valid, ex_ALUOp, ex_wreg, bubble_cnt} !== {1'b1, 4'd1, 5'd9, CNT_W'(1)}) begin
            n_err++; $display("FAIL load_use_advance: got v=%b op=%0d wreg=%0d cnt=%0d want 1/1/9/1",
                              ex_valid, ex_ALUOp, ex_wreg, bubble_cnt);
        end
        $display("test_load_use: bubble_cnt=%0d", bubble_cnt);
    endtask

    task automatic test_no_false_stall();
        logic [14:0] user_ctl [0:2];
        logic [4:0]  lw_rt [0:2];
        logic [4:0]  u_rs [0:2];
        logic [4:0]  u_rt [0:2];
        user_ctl = '{CTL_ADD, CTL_ADDI, CTL_SLL};
        lw_rt    = '{5'd0, 5'd8, 5'd8};
        u_rs     = '{5'd0, 5'd1, 5'd8};
        u_rt     = '{5'd0, 5'd8, 5'd2};
        for (int i = 0; i < 3; i++) begin
            drive(CTL_LW, 5'd1, lw_rt[i], 5'd0);
            #1; tick();
            drive(user_ctl[i], u_rs[i], u_rt[i], 5'd4);
            #1;
            n_cmp++;
            if ({pc_write, ifid_write} !== 2'b11) begin
                n_err++; $display("FAIL no_stall_%0d: got %b want 11", i, {pc_write, ifid_write});
            end
            tick();
            n_cmp++;
            if (ex_valid !== 1'b1 || obs_state !== exp_state()) begin
                n_err++; $display("FAIL no_stall_state_%0d: got %h want %h", i, obs_state, exp_state());
            end
            $display("test_no_false_stall[%0d]: pc_write held 1, ex_valid=%b", i, ex_valid);
        end
    endtask

    task automatic test_flush_priority();
        logic [CNT_W-1:0] cnt0;
        cnt0 = CNT_W'(m_cnt);
        drive(CTL_LW, 5'd1, 5'd8, 5'd0);
        #1; tick();
        drive(CTL_ADD, 5'd8, 5'd3, 5'd9);
        flush = 1'b1;
        #1;
        n_cmp++;
        if ({pc_write, ifid_write} !== 2'b11) begin
            n_err++; $display("FAIL flush_pc_write: got %b want 11", {pc_write, ifid_write});
        end
        tick();
        flush = 1'b0;
        n_cmp++;
        if ({ex_valid, obs_ctrl, ex_wreg} !== '0 || bubble_cnt !== cnt0) begin
            n_err++; $display("FAIL flush_bubble: got ctrl=%h v=%b cnt=%0d want 0/0/%0d",
                              obs_ctrl, ex_valid, bubble_cnt, cnt0);
        end
        $display("test_flush_priority: bubble_cnt=%0d", bubble_cnt);
    endtask

    task automatic test_hold();
        logic [CNT_W-1:0] cnt0;
        drive(CTL_ADD, 5'd1, 5'd2, 5'd7);
        #1; tick();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(KINDS[$urandom_range(0, 8)], 5'($urandom), 5'($urandom), 5'($urandom));
            #1;
            n_cmp++;
            if ({pc_write, ifid_write} !== 2'b00) begin
                n_err++; $display("FAIL hold_pc_%0d: got %b want 00", i, {pc_write, ifid_write});
            end
            tick();
            n_cmp++;
            if ({ex_valid, ex_ALUOp, ex_wreg} !== {1'b1, 4'd1, 5'd7} || obs_state !== exp_state()) begin
                n_err++; $display("FAIL hold_frozen_%0d: got %h want %h", i, obs_state, exp_state());
            end
        end
        hold = 1'b0;
        // Pending load-use under hold: no bubble until hold drops.
        drive(CTL_LW, 5'd1, 5'd8, 5'd0);
        #1; tick();
        cnt0 = CNT_W'(m_cnt);
        drive(CTL_ADD, 5'd8, 5'd3, 5'd9);
        hold = 1'b1;
        #1; tick(); tick();
        n_cmp++;
        if (ex_MemtoReg !== 1'b1 || bubble_cnt !== cnt0) begin
            n_err++; $display("FAIL hold_pending: got memtoreg=%b cnt=%0d want 1/%0d",
                              ex_MemtoReg, bubble_cnt, cnt0);
        end
        hold = 1'b0;
        #1;
        n_cmp++;
        if ({pc_write, ifid_write} !== 2'b00) begin
            n_err++; $display("FAIL hold_restall: got %b want 00", {pc_write, ifid_write});
        end
        tick();
        n_cmp++;
        if (ex_valid !== 1'b0 || bubble_cnt !== cnt0 + CNT_W'(1)) begin
            n_err++; $display("FAIL hold_bubble: got v=%b cnt=%0d want 0/%0d", ex_valid, bubble_cnt, cnt0 + 1);
        end
        $display("test_hold: bubble_cnt=%0d", bubble_cnt);
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            drive(KINDS[$urandom_range(0, 8)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)));
            id_valid = ($urandom_range(0, 9) != 0);
            rst      = ($urandom_range(0, 99) == 0);
            hold     = ($urandom_range(0, 9) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            #1;
            n_cmp++;
            if ({pc_write, ifid_write} !== exp_pc()) begin
                n_err++; bad++;
                $display("FAIL random_pc_%0d: got %b want %b", i, {pc_write, ifid_write}, exp_pc());
            end
            tick();
            n_cmp++;
            if (obs_state !== exp_state() || (m_valid && obs_data !== m_data)) begin
                n_err++; bad++;
                $display("FAIL random_state_%0d: got %h want %h", i, obs_state, exp_state());
            end
        end
        rst = 1'b0; hold = 1'b0; flush = 1'b0;
        $display("test_random: 400 cycles, %0d bad, bubble_cnt=%0d", bad, bubble_cnt);
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        #1; tick();
        rst = 1'b0;
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            drive(CTL_LW, 5'd1, 5'd8, 5'd0);
            #1; tick();
            drive(CTL_ADD, 5'd8, 5'd1, 5'd9);
            #1; tick(); tick();
        end
        n_cmp++;
        if (bubble_cnt !== CNT_W'(CNT_MAX) || obs_state !== exp_state()) begin
            n_err++; $display("FAIL saturation: got cnt=%0d want %0d", bubble_cnt, CNT_MAX);
        end
        $display("test_saturation: bubble_cnt=%0d", bubble_cnt);
    endtask

    initial begin
        test_reset();
        test_capture();
        test_load_use();
        test_no_false_stall();
        test_flush_priority();
        test_hold();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register sitting directly downstream of the decode Controller in the 5-stage MIPS pipeline.
- Captures Controller outputs, register-file operands, the sign-extended immediate and register fields.
- Computes the EX destination register.
- Detects load-use hazards; on a hazard it stalls PC and IF/ID and inserts a bubble.
- Applies branch/jump flushes and counts inserted bubbles.

Parameters:
- DATA_W, 32, width of operand, immediate and PC datapaths.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous active-high reset.
- hold  in  1  global freeze from memory stall; all state holds.
- flush  in  1  branch taken / jump redirect from EX; kill the ID instruction.
- id_valid  in  1  IF/ID holds a real instruction.
- id_RegDst, id_RegWrite, id_ALUSrc, id_MemWrite, id_MemtoReg, id_Branch, id_Jump, id_Jal, id_Jr, id_lw_or_lh, id_sw_or_sh  in  1 each  Controller outputs.
- id_ALUOp  in  4  Controller ALU op (1 add … 8 sll, 9 srl, 10 beq, 11 bne).
- id_rs, id_rt, id_rd, id_shamt  in  5 each  instruction fields.
- id_rs_data, id_rt_data, id_imm, id_pc4  in  DATA_W each  operands, sign-extended immediate, PC+4.
- ex_* (same names and widths as each id_* data/control input, plus ex_valid)  out  registered copies.
- ex_wreg  out  5  EX destination: 31 if Jal, else rd if RegDst, else rt.
- pc_write  out  1  0 = hold PC (comb).
- ifid_write  out  1  0 = hold IF/ID (comb).
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles.

Behaviour:
- Reset (rst=1 at posedge): every ex_* output and bubble_cnt become 0 (ex_ALUOp=0 is nop, ex_valid=0, ex_wreg=0).
  - pc_write and ifid_write are driven 1 while rst=1.
  - Reset mid-stall discards the stall.
- Hazard detect is combinational. load_use = id_valid & ex_valid & ex_MemtoReg & ex_RegWrite & (ex_wreg!=0) & ((uses_rs & ex_wreg==id_rs) | (uses_rt & ex_wreg==id_rt)).
  - uses_rs = !(id_Jump & !id_Jr) & id_ALUOp!=8 & id_ALUOp!=9.
  - uses_rt = !id_ALUSrc | id_MemWrite.
- pc_write = ifid_write = !(hold | (load_use & !flush)).
- Per-posedge update priority is rst > hold > flush > load_use > capture:
  - hold: all registers keep their value.
  - flush: bubble. All control outputs become 0, ex_valid=0, ex_wreg=0. Data fields are don't-care but are captured. bubble_cnt is not incremented.
  - load_use: bubble as above; bubble_cnt += 1, saturating at all-ones.
  - capture: every ex_* takes its id_* value; ex_valid=id_valid; ex_wreg is computed from the id fields.
    - If id_valid=0, control outputs are zeroed as in a bubble, and no count.
- Latency: 1 cycle ID→EX. A load-use stall lasts exactly 1 cycle, because the load advances to MEM and the hazard clears.
- hold during a pending load_use: no bubble is inserted and no count. The stall re-evaluates after hold drops.
- flush and load_use together: flush wins. pc_write=1 so the redirect proceeds; no count.
- A stall only bubbles ID/EX. Downstream stages are never frozen by this block.

Decomposition:
- Shared package: ALU op constants (nop 0 … bne 11), JAL_REG=5'd31, and a packed control-bundle typedef (RegDst … sw_or_sh, ALUOp) used by Controller, id_ex_stage and ex_mem_stage.
- One sub-module, hazard_detect: combinational load_use/uses_rs/uses_rt logic, reused by later forwarding work.
- The register and counter logic stay in id_ex_stage.

Test Plan:
- Reset: drive all inputs nonzero with rst=1 for 2 cycles → every ex_* = 0, bubble_cnt = 0, pc_write = 1.
- Straight capture: add (RegDst=1, RegWrite=1, ALUOp=1, rd=5, rs_data=0x10, rt_data=0x20) → next cycle ex_ALUOp=1, ex_wreg=5, ex_rs_data=0x10, ex_valid=1.
- Load-use: lw to rt=8, then add with rs=8 → pc_write=ifid_write=0 for 1 cycle; EX receives a bubble (ex_RegWrite=0); the add enters EX on the following cycle; bubble_cnt=1.
- No false stall:
  - lw to $0, then use of $0 → no stall.
  - lw to 8, then addi with rt=8 (ALUSrc=1, uses_rt=0) → no stall.
  - lw to 8, then sll with rs=8 → no stall.
- Flush priority: load_use and flush asserted together → pc_write=1, ex control = 0, bubble_cnt unchanged.
- Hold: hold=1 for 3 cycles with changing id_* inputs → ex_* frozen and pc_write=0. Then counter saturation: preload by forcing 0xFFFF hazards → bubble_cnt stays at 0xFFFF.
